// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stateful hazard unit beside the D/E/M/W pipeline.
// Tracks in-flight GPR producers in a tag pipeline e[1..NSTAGE], raises the
// D-stage stall, drives per-stage/per-operand forward selects and owns the
// HI/LO multi-cycle busy counter.
// Optional build macro HZ_STALL_CNT_EN adds stall_cnt / md_stall_cnt outputs.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int NSTAGE = 3,
  parameter int MD_LAT = 5,
  localparam int SW    = $clog2(NSTAGE + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       d_valid,
  input  logic [NSRC*REG_AW-1:0]     d_src_addr,
  input  logic [NSRC-1:0]            d_src_use,
  input  logic [NSRC*SW-1:0]         d_src_need,
  input  logic                       d_dst_we,
  input  logic [REG_AW-1:0]          d_dst_addr,
  input  logic [SW-1:0]              d_dst_rdy,
  input  logic                       d_md_use,
  input  logic                       d_md_start,
  input  logic                       flush,
  output logic                       stall,
  output logic [NSTAGE*NSRC*SW-1:0]  fwd_sel,
  output logic                       md_busy
`ifdef HZ_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                md_stall_cnt
`endif
);

  localparam int MW = $clog2(MD_LAT + 1);

  // Tag pipeline. Source fields are only needed by consumer stages below
  // NSTAGE, and md_start only matters while the op sits in E.
  logic [NSTAGE:1]          valid_reg;
  logic [NSTAGE:1]          we_reg;
  logic [REG_AW-1:0]        dst_reg      [1:NSTAGE];
  logic [SW-1:0]            rdy_reg      [1:NSTAGE];
  logic                     md_start_reg;
  logic [NSRC*REG_AW-1:0]   src_addr_reg [1:NSTAGE-1];
  logic [NSRC-1:0]          src_use_reg  [1:NSTAGE-1];
  logic [MW-1:0]            md_cnt_reg;

  logic [NSRC*REG_AW-1:0]   cons_addr [0:NSTAGE-1];
  logic [NSRC-1:0]          cons_use  [0:NSTAGE-1];
  logic [REG_AW-1:0]        fwd_src;
  logic [SW-1:0]            fwd_val;
  logic [REG_AW-1:0]        gpr_src;
  logic [SW-1:0]            gpr_hit_s;
  logic [SW-1:0]            gpr_hit_rdy;
  logic                     gpr_stall;
  logic                     md_stall;

  // Consumer view per stage: stage 0 is the live D inputs.
  always_comb begin
    cons_addr[0] = d_src_addr;
    cons_use[0]  = d_src_use;
    for (int k = 1; k < NSTAGE; k++) begin
      cons_addr[k] = src_addr_reg[k];
      cons_use[k]  = src_use_reg[k];
    end
  end

  // Forward selects: youngest matching producer wins, and only if its result
  // already sits in its pipe register.
  always_comb begin
    fwd_sel = '0;
    fwd_src = '0;
    fwd_val = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      for (int j = 0; j < NSRC; j++) begin
        fwd_src = cons_addr[k][j*REG_AW +: REG_AW];
        fwd_val = '0;
        for (int s = NSTAGE; s > k; s--) begin
          if (cons_use[k][j] && (fwd_src != '0) && valid_reg[s] && we_reg[s] &&
              (dst_reg[s] == fwd_src)) begin
            fwd_val = (s >= int'(rdy_reg[s])) ? SW'(s) : '0;
          end
        end
        fwd_sel[(k*NSRC+j)*SW +: SW] = fwd_val;
      end
    end
  end

  // GPR stall: the youngest D-operand producer cannot deliver by the stage
  // where the operand is consumed.
  always_comb begin
    gpr_stall   = 1'b0;
    gpr_src     = '0;
    gpr_hit_s   = '0;
    gpr_hit_rdy = '0;
    for (int j = 0; j < NSRC; j++) begin
      gpr_src     = d_src_addr[j*REG_AW +: REG_AW];
      gpr_hit_s   = '0;
      gpr_hit_rdy = '0;
      for (int s = NSTAGE; s >= 1; s--) begin
        if (d_src_use[j] && (gpr_src != '0) && valid_reg[s] && we_reg[s] &&
            (dst_reg[s] == gpr_src)) begin
          gpr_hit_s   = SW'(s);
          gpr_hit_rdy = rdy_reg[s];
        end
      end
      if (d_valid && (gpr_hit_s != '0) &&
          (int'(gpr_hit_s) + int'(d_src_need[j*SW +: SW]) < int'(gpr_hit_rdy))) begin
        gpr_stall = 1'b1;
      end
    end
  end

  // HI/LO interlock and the combined stall; flush and reset both kill it at once.
  assign md_busy  = rst_n & (md_cnt_reg != '0);
  assign md_stall = d_valid & d_md_use & (md_busy | (valid_reg[1] & md_start_reg));
  assign stall    = rst_n & ~flush & (gpr_stall | md_stall);

  // Tag pipeline advance: E/M/W always move, E takes a bubble when D holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= '0;
      we_reg       <= '0;
      md_start_reg <= 1'b0;
      for (int s = 1; s <= NSTAGE; s++) begin
        dst_reg[s] <= '0;
        rdy_reg[s] <= '0;
      end
      for (int s = 1; s < NSTAGE; s++) begin
        src_addr_reg[s] <= '0;
        src_use_reg[s]  <= '0;
      end
    end else begin
      for (int s = NSTAGE; s >= 2; s--) begin
        valid_reg[s] <= valid_reg[s-1] & ~flush;
        we_reg[s]    <= we_reg[s-1];
        dst_reg[s]   <= dst_reg[s-1];
        rdy_reg[s]   <= rdy_reg[s-1];
      end
      for (int s = NSTAGE - 1; s >= 2; s--) begin
        src_addr_reg[s] <= src_addr_reg[s-1];
        src_use_reg[s]  <= src_use_reg[s-1];
      end
      valid_reg[1]    <= d_valid & ~stall & ~flush;
      we_reg[1]       <= d_dst_we & (d_dst_addr != '0);
      dst_reg[1]      <= d_dst_addr;
      rdy_reg[1]      <= d_dst_rdy;
      md_start_reg    <= d_md_start;
      src_addr_reg[1] <= d_src_addr;
      src_use_reg[1]  <= d_src_use;
    end
  end

  // HI/LO busy counter: reload on mult/div in E, else count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_reg <= '0;
    end else if (valid_reg[1] && md_start_reg) begin
      md_cnt_reg <= MW'(MD_LAT);
    end else if (md_cnt_reg != '0) begin
      md_cnt_reg <= md_cnt_reg - 1'b1;
    end
  end

`ifdef HZ_STALL_CNT_EN
  // Free-running wrap-around stall statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall)            stall_cnt    <= stall_cnt + 32'd1;
      if (stall && md_stall) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: table of producer/consumer pairs plus
// hand-written multi-cycle sequences (HI/LO interlock, flush, async reset).
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int NSTAGE = 3;
  localparam int SW     = 2;

  logic                      clk;
  logic                      rst_n;
  logic                      d_valid;
  logic [NSRC*REG_AW-1:0]    d_src_addr;
  logic [NSRC-1:0]           d_src_use;
  logic [NSRC*SW-1:0]        d_src_need;
  logic                      d_dst_we;
  logic [REG_AW-1:0]         d_dst_addr;
  logic [SW-1:0]             d_dst_rdy;
  logic                      d_md_use;
  logic                      d_md_start;
  logic                      flush;
  logic                      stall;
  logic [NSTAGE*NSRC*SW-1:0] fwd_sel;
  logic                      md_busy;
`ifdef HZ_STALL_CNT_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               md_stall_cnt;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_src_addr(d_src_addr),
    .d_src_use(d_src_use), .d_src_need(d_src_need), .d_dst_we(d_dst_we),
    .d_dst_addr(d_dst_addr), .d_dst_rdy(d_dst_rdy), .d_md_use(d_md_use),
    .d_md_start(d_md_start), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
    .md_busy(md_busy)
`ifdef HZ_STALL_CNT_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int p_dst, p_rdy, p_we, gap;
    int c_src0, c_src1, c_use, c_need0, c_need1;
    int exp_stalls, exp_k, exp_j, exp_fwd;
  } vec_t;

  typedef struct {
    string name;
    int    val;
  } exp_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string name, input int val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int actual);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %0d with nothing expected", actual);
    end else begin
      e = exp_q.pop_front();
      if (actual != e.val) begin
        n_bad++;
        $display("FAIL %s: got %0d required %0d", e.name, actual, e.val);
      end else begin
        $display("ok   %s: %0d", e.name, actual);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input int valid, input int src0, input int src1, input int use_bits,
                         input int need0, input int need1, input int we, input int dst,
                         input int rdy, input int md_use, input int md_start);
    d_valid    = valid[0];
    d_src_addr = {src1[4:0], src0[4:0]};
    d_src_use  = use_bits[1:0];
    d_src_need = {need1[1:0], need0[1:0]};
    d_dst_we   = we[0];
    d_dst_addr = dst[4:0];
    d_dst_rdy  = rdy[1:0];
    d_md_use   = md_use[0];
    d_md_start = md_start[0];
  endtask

  task automatic idle();
    drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  // Hold the current D instruction until it stops stalling; returns stall
  // and md_busy cycle counts, sitting at the negedge of the issuing cycle.
  task automatic wait_issue(output int n_stall, output int n_busy, output int timed_out);
    n_stall   = 0;
    n_busy    = 0;
    timed_out = 0;
    @(negedge clk);
    while (stall) begin
      n_stall++;
      if (md_busy) n_busy++;
      if (n_stall > 12) begin
        timed_out = 1;
        break;
      end
      tick();
      @(negedge clk);
    end
  endtask

  int ns, nb, to;
  logic [SW-1:0] fv;

  initial begin
    // name         dst rdy we gap  s0 s1 use n0 n1  stalls k j fwd
    vecs[0]  = '{"alu_beq",      3, 2, 1, 0,  3, 4, 3, 0, 0,  1, 0, 0, 2};
    vecs[1]  = '{"lw_alu",       5, 3, 1, 0,  5, 1, 3, 1, 1,  1, 1, 0, 3};
    vecs[2]  = '{"lw_beq",       5, 3, 1, 0,  5, 0, 3, 0, 0,  2, 0, 0, 3};
    vecs[3]  = '{"r0_beq_j0",    0, 2, 1, 0,  0, 0, 3, 0, 0,  0, 0, 0, 0};
    vecs[4]  = '{"r0_beq_j1",    0, 2, 1, 0,  0, 0, 3, 0, 0,  0, 0, 1, 0};
    vecs[5]  = '{"alu_gap1_beq", 3, 2, 1, 1,  3, 0, 3, 0, 0,  0, 0, 0, 2};
    vecs[6]  = '{"alu_alu_j1",   9, 2, 1, 0,  2, 9, 3, 1, 1,  0, 1, 1, 2};
    vecs[7]  = '{"jal_jr",      31, 1, 1, 0, 31, 0, 3, 0, 0,  0, 0, 0, 1};
    vecs[8]  = '{"no_match",    12, 2, 1, 0, 13,14, 3, 0, 0,  0, 0, 0, 0};
    vecs[9]  = '{"lw_sw_data",   8, 3, 1, 0,  2, 8, 3, 1, 2,  0, 2, 1, 3};
    vecs[10] = '{"lw_gap2_beq",  5, 3, 1, 2,  5, 0, 3, 0, 0,  0, 0, 0, 3};
    vecs[11] = '{"no_we",        3, 2, 0, 0,  3, 0, 3, 0, 0,  0, 0, 0, 0};
    vecs[12] = '{"unused_src",   3, 2, 1, 0,  3, 0, 2, 0, 0,  0, 0, 0, 0};

    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    push("reset_stall", 0);   pop_check(int'(stall));
    push("reset_md_busy", 0); pop_check(int'(md_busy));
    push("reset_fwd_sel", 0); pop_check(int'(fwd_sel));
`ifdef HZ_STALL_CNT_EN
    push("reset_stall_cnt", 0);    pop_check(int'(stall_cnt));
    push("reset_md_stall_cnt", 0); pop_check(int'(md_stall_cnt));
`endif

    // Producer/consumer table
    for (int v = 0; v < NVEC; v++) begin
      drain(4);
      drive_d(1, 0, 0, 0, 0, 0, vecs[v].p_we, vecs[v].p_dst, vecs[v].p_rdy, 0, 0);
      tick();
      drain(vecs[v].gap);
      drive_d(1, vecs[v].c_src0, vecs[v].c_src1, vecs[v].c_use, vecs[v].c_need0,
              vecs[v].c_need1, 0, 0, 0, 0, 0);
      push({vecs[v].name, "_stalls"}, vecs[v].exp_stalls);
      push({vecs[v].name, "_fwd"}, vecs[v].exp_fwd);
      wait_issue(ns, nb, to);
      if (vecs[v].exp_k > 0) begin
        tick();
        idle();
        repeat (vecs[v].exp_k - 1) tick();
        @(negedge clk);
      end
      fv = fwd_sel[(vecs[v].exp_k*NSRC + vecs[v].exp_j)*SW +: SW];
      pop_check(to ? -1 : ns);
      pop_check(int'(fv));
    end

    // Youngest producer shadows older one: addu $7 (now M), ori $7 (now E).
    // At D the E copy is not yet ready so the select is 0, not the older M (2);
    // one stage later the consumer must pick M (2), not W (3).
    drain(4);
    drive_d(1, 0, 0, 0, 0, 0, 1, 7, 2, 0, 0); tick();
    drive_d(1, 0, 0, 0, 0, 0, 1, 7, 2, 0, 0); tick();
    drive_d(1, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    push("shadow_stall", 0);
    push("shadow_fwd_k0", 0);
    push("shadow_fwd_k1", 2);
    @(negedge clk);
    pop_check(int'(stall));
    pop_check(int'(fwd_sel[1:0]));
    tick(); idle();
    @(negedge clk);
    pop_check(int'(fwd_sel[(1*NSRC+0)*SW +: SW]));

    // mult enters E, mflo waits MD_LAT+1 cycles, md_busy high for 5 of them
    drain(8);
    drive_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    push("md_stalls", 6);
    push("md_busy_cycles", 5);
    push("md_busy_at_issue", 0);
    wait_issue(ns, nb, to);
    pop_check(to ? -1 : ns);
    pop_check(nb);
    pop_check(int'(md_busy));

    // flush in the middle of an MD stall
    drain(8);
    drive_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    push("flush_pre_stall", 1);
    @(negedge clk); pop_check(int'(stall));
    tick(); tick();
    flush = 1'b1;
    push("flush_stall", 0);
    push("flush_md_busy", 1);
    @(negedge clk);
    pop_check(int'(stall));
    pop_check(int'(md_busy));
    tick();
    flush = 1'b0;
    push("post_flush_stalls", 3);
    wait_issue(ns, nb, to);
    pop_check(to ? -1 : ns);

    // async reset during a GPR stall with HI/LO busy
    drain(8);
    drive_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive_d(1, 0, 0, 0, 0, 0, 1, 5, 3, 0, 0); tick();
    drive_d(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    push("prerst_stall", 1);
    push("prerst_md_busy", 1);
    @(negedge clk);
    pop_check(int'(stall));
    pop_check(int'(md_busy));
    #1 rst_n = 1'b0;
    #1;
    push("rst_stall", 0);
    push("rst_md_busy", 0);
    push("rst_fwd_sel", 0);
    pop_check(int'(stall));
    pop_check(int'(md_busy));
    pop_check(int'(fwd_sel));
    @(posedge clk);
    #1 rst_n = 1'b1;
    push("postrst_stall", 0);
    @(negedge clk);
    pop_check(int'(stall));

`ifdef HZ_STALL_CNT_EN
    // 6 MD stall cycles followed by 1 GPR stall cycle
    drain(2);
    drive_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    drive_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    wait_issue(ns, nb, to);
    tick();
    drive_d(1, 0, 0, 0, 0, 0, 1, 3, 2, 0, 0); tick();
    drive_d(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    wait_issue(ns, nb, to);
    tick(); idle();
    push("stall_cnt", 7);
    push("md_stall_cnt", 6);
    @(negedge clk);
    pop_check(int'(stall_cnt));
    pop_check(int'(md_stall_cnt));
`endif

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends with a summary.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
